multi_edge_event_detector: RTL
==============================

// Module: multi_edge_event_detector
// PURPOSE
//   Parametrised multi-channel edge detector for asynchronous control inputs (start/abort strobes).
//   Per channel: synchronise, glitch-filter, detect rising/falling/both edges per mode, emit a 1-cycle pulse.
//   Also keeps a sticky pending flag with write-1-to-clear and a sticky overflow flag.
//   Sits between external strobe pins and the controller FSMs; replaces single-bit edge detectors.
// PARAMETERS
//   NUM_CH        4  number of independent input channels (>=1)
//   SYNC_STAGES   2  synchroniser flops per channel (>=2)
//   FILTER_CYCLES 3  consecutive differing synced samples needed to accept a level change (>=1)
// PORTS
//   clk            in   1       system clock, all state on rising edge
//   n_rst          in   1       asynchronous active-low reset
//   data_in        in   NUM_CH  raw asynchronous inputs
//   mode           in   2       00 off, 01 rising, 10 falling, 11 both (shared by all channels)
//   clear          in   NUM_CH  W1C: clears pending[i] and overflow[i]
//   edge_pulse     out  NUM_CH  1-cycle pulse per detected edge (registered)
//   pending        out  NUM_CH  sticky: edge seen since last clear
//   overflow       out  NUM_CH  sticky: edge seen while pending already set
//   any_pending    out  1       OR-reduction of pending
// BEHAVIOUR
//   Reset (n_rst=0, async): sync chain, filtered level lvl[i], counters, edge_pulse, pending, overflow all 0.
//   Synchroniser: s[i] = data_in[i] delayed SYNC_STAGES edges; no other logic in the chain.
//   Filter (per channel): counter cnt width $clog2(FILTER_CYCLES+1).
//     - s[i]==lvl[i]: cnt <= 0.
//     - s[i]!=lvl[i] and cnt==FILTER_CYCLES-1: lvl[i] <= s[i], cnt <= 0 (accept edge).
//     - otherwise cnt <= cnt+1. Counter never wraps.
//     - Any glitch shorter than FILTER_CYCLES synced samples is dropped entirely.
//   Detection: on the edge that updates lvl[i], edge_pulse[i] <= 1 if
//     (rise: old 0->1 and mode[0]) or (fall: old 1->0 and mode[1]); else edge_pulse[i] <= 0.
//     - edge_pulse is high for exactly one cycle per accepted edge.
//   Latency: input stable from edge k; edge_pulse high after edge k+SYNC_STAGES+FILTER_CYCLES-1.
//     - Defaults: pulse visible 4 cycles after first sampling edge.
//   Mode: sampled at the lvl-update edge only.
//     - Filtering and lvl tracking continue in mode 00; mode changes never create pulses.
//   pending[i]: set on edge_pulse set condition; cleared by clear[i].
//     - Same-cycle new edge and clear[i]: pending stays 1 (set wins).
//   overflow[i]: set when a new edge occurs while pending[i]==1 and clear[i]==0.
//     - Cleared by clear[i]. Same-cycle new edge and clear: overflow <= 0.
//   clear[i] with no pending: no effect, no error.
//   any_pending: combinational OR of pending registers; no input-to-output combinational path.
//   Power-up edge: lvl resets to 0, so an input held high through reset produces one rising edge after latency.
//   Reset mid-filter: counts discarded. After release, filtering restarts from lvl=0.
//   Channels fully independent; simultaneous edges on all channels each pulse in the same cycle.
// TESTING
//   1 Defaults, mode=01, ch0 0->1 held: edge_pulse[0] high exactly 1 cycle, 4 cycles after first sample;
//     pending[0]=1, any_pending=1.
//   2 mode=01, ch1 high for 2 cycles then low (glitch < FILTER_CYCLES): no pulse, pending[1] stays 0.
//   3 mode=11, ch2 0->1, then 1->0 after 10 cycles: two pulses.
//     - pending[2]=1 after the first, overflow[2]=1 after the second.
//     - clear=4'b0100 -> both 0 next cycle.
//   4 mode=10, ch3 rise then fall: pulse only on fall.
//     - Then mode=00, another rise/fall: no pulses, lvl still tracks (next mode=01 rise pulses normally).
//   5 clear[0] asserted in same cycle as ch0 edge_pulse with pending[0]=1: pending[0]=1, overflow[0]=0.
//   6 data_in=4'hF held through reset; n_rst deasserted: one rising pulse on all 4 channels together.
//     - Then assert n_rst mid-filter: all outputs 0 immediately (async).

Source files
------------

// File: rtl/multi_edge_event_detector.sv
// Multi-channel edge detector: synchroniser, glitch filter, mode-selected edge pulse,
// and sticky pending/overflow flags with write-1-to-clear.
module multi_edge_event_detector #(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 3
) (
   input  logic              i_clk,
   input  logic              i_n_rst,
   input  logic [NUM_CH-1:0] i_data_in,
   input  logic [1:0]        i_mode,
   input  logic [NUM_CH-1:0] i_clear,
   output logic [NUM_CH-1:0] o_edge_pulse,
   output logic [NUM_CH-1:0] o_pending,
   output logic [NUM_CH-1:0] o_overflow,
   output logic              o_any_pending
);

   localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
   logic [NUM_CH-1:0][CntW-1:0]        r_cnt;
   logic [NUM_CH-1:0][CntW-1:0]        w_cnt_d;
   logic [NUM_CH-1:0]                  r_lvl;
   logic [NUM_CH-1:0]                  w_lvl_d;
   logic [NUM_CH-1:0]                  r_pulse;
   logic [NUM_CH-1:0]                  w_pulse_d;
   logic [NUM_CH-1:0]                  r_pend;
   logic [NUM_CH-1:0]                  w_pend_d;
   logic [NUM_CH-1:0]                  r_ovf;
   logic [NUM_CH-1:0]                  w_ovf_d;
   logic [NUM_CH-1:0]                  w_s;

   assign w_s = r_sync[SYNC_STAGES-1];

   // A level change is accepted only after FILTER_CYCLES consecutive differing samples.
   always_comb begin
      w_cnt_d   = r_cnt;
      w_lvl_d   = r_lvl;
      w_pulse_d = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (w_s[i] == r_lvl[i]) begin
            w_cnt_d[i] = '0;
         end else if (r_cnt[i] == CntMax) begin
            w_lvl_d[i]   = w_s[i];
            w_cnt_d[i]   = '0;
            w_pulse_d[i] = (w_s[i] & i_mode[0]) | (~w_s[i] & i_mode[1]);
         end else begin
            w_cnt_d[i] = r_cnt[i] + CntW'(1);
         end
      end
   end

   // A new edge beats a same-cycle clear for pending, but clear wins for overflow.
   always_comb begin
      w_pend_d = (r_pend & ~i_clear) | w_pulse_d;
      w_ovf_d  = (r_ovf & ~i_clear) | (w_pulse_d & r_pend & ~i_clear);
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_lvl   <= '0;
         r_pulse <= '0;
         r_pend  <= '0;
         r_ovf   <= '0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_data_in};
         r_cnt   <= w_cnt_d;
         r_lvl   <= w_lvl_d;
         r_pulse <= w_pulse_d;
         r_pend  <= w_pend_d;
         r_ovf   <= w_ovf_d;
      end
   end

   assign o_edge_pulse  = r_pulse;
   assign o_pending     = r_pend;
   assign o_overflow    = r_ovf;
   assign o_any_pending = |r_pend;

endmodule
